// File: rtl/eth_rx_mac_pkg.sv
// Shared Ethernet rx/tx definitions: framing bytes, frame size limits, CRC-32 constants,
// the byte-wise CRC step and the receive FSM state type.
package eth_rx_mac_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE        = 8'h55;
  localparam logic [7:0]  SFD_BYTE             = 8'hD5;
  localparam logic [10:0] MIN_FRAME_SIZE       = 11'd64;
  localparam logic [10:0] MAX_FRAME_SIZE       = 11'd1518;
  localparam logic [31:0] CRC32_POLY_REFLECTED = 32'hEDB88320;
  localparam logic [31:0] CRC32_RESIDUE        = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_t;

  // Reflected (LSB-first) CRC-32 update for one byte, no inversion.
  function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFLECTED) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_rx_mac_crc_chk.sv
// CRC-32 running checker: init loads all-ones, enabled bytes fold in, match flags the
// good-frame residue once the FCS bytes have been absorbed.
module eth_rx_crc_chk
  import eth_rx_mac_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_init,
  input  logic       i_en,
  input  logic [7:0] i_data,
  output logic       o_match
);

  logic [31:0] r_crc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= 32'hFFFFFFFF;
    end else if (i_init) begin
      r_crc <= 32'hFFFFFFFF;
    end else if (i_en) begin
      r_crc <= crc32_step(r_crc, i_data);
    end
  end

  assign o_match = (r_crc == CRC32_RESIDUE);

endmodule

// File: rtl/eth_rx_mac.sv
// GMII receive framer: strips preamble/SFD, checks FCS and length, drops the FCS bytes.
// m_valid marks a byte on m_data every cycle it is high; there is no ready, the sink takes
// every byte. Optional frame counters are built when ETH_RX_STATS_EN is defined.
module eth_rx_mac
  import eth_rx_mac_pkg::*;
#(
  parameter int PREAMBLE_MIN = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_dv,
  input  logic        rx_er,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  output logic        stat_valid,
  output logic        stat_crc_err,
  output logic        stat_len_err,
  output logic        stat_phy_err,
  output logic [31:0] cnt_good,
  output logic [31:0] cnt_bad,
  output logic [1:0]  dbg_state
);

  localparam logic [2:0] PRE_MIN = 3'(PREAMBLE_MIN);

  rx_state_t   r_state;
  logic        r_dv_q;
  logic [2:0]  r_pre_cnt;
  logic [10:0] r_len;
  logic        r_phy_err;
  logic [7:0]  r_buf [5];

  logic w_start;
  logic w_pre_ok;
  logic w_crc_init;
  logic w_crc_en;
  logic w_crc_match;
  logic w_len_err;
  logic w_buf_full;

  // r_dv_q resets high so a frame already in flight at reset release is ignored.
  assign w_start    = rx_dv & ~r_dv_q;
  assign w_pre_ok   = (r_pre_cnt >= PRE_MIN);
  assign w_crc_init = (r_state == ST_PREAMBLE) && rx_dv && (rx_data == SFD_BYTE) && w_pre_ok;
  assign w_crc_en   = (r_state == ST_DATA) && rx_dv;
  assign w_len_err  = (r_len < MIN_FRAME_SIZE) || (r_len > MAX_FRAME_SIZE);
  assign w_buf_full = (r_len >= 11'd5);
  assign dbg_state  = r_state;

  eth_rx_crc_chk u_crc (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_init  (w_crc_init),
    .i_en    (w_crc_en),
    .i_data  (rx_data),
    .o_match (w_crc_match)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_dv_q       <= 1'b1;
      r_pre_cnt    <= 3'd0;
      r_len        <= 11'd0;
      r_phy_err    <= 1'b0;
      m_data       <= 8'h00;
      m_valid      <= 1'b0;
      m_last       <= 1'b0;
      stat_valid   <= 1'b0;
      stat_crc_err <= 1'b0;
      stat_len_err <= 1'b0;
      stat_phy_err <= 1'b0;
      for (int i = 0; i < 5; i++) r_buf[i] <= 8'h00;
    end else begin
      r_dv_q       <= rx_dv;
      m_data       <= 8'h00;
      m_valid      <= 1'b0;
      m_last       <= 1'b0;
      stat_valid   <= 1'b0;
      stat_crc_err <= 1'b0;
      stat_len_err <= 1'b0;
      stat_phy_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            if (rx_data == PREAMBLE_BYTE) begin
              r_state   <= ST_PREAMBLE;
              r_pre_cnt <= 3'd1;
            end else begin
              r_state <= ST_DROP;
            end
          end
        end
        ST_PREAMBLE: begin
          if (!rx_dv) begin
            r_state <= ST_IDLE;
          end else if (rx_data == PREAMBLE_BYTE) begin
            if (r_pre_cnt != 3'd7) r_pre_cnt <= r_pre_cnt + 3'd1;
          end else if (w_crc_init) begin
            r_state   <= ST_DATA;
            r_len     <= 11'd0;
            r_phy_err <= 1'b0;
          end else begin
            r_state <= ST_DROP;
          end
        end
        ST_DATA: begin
          if (rx_dv) begin
            if (r_len != 11'h7FF) r_len <= r_len + 11'd1;
            if (rx_er) r_phy_err <= 1'b1;
            r_buf[0] <= rx_data;
            for (int i = 1; i < 5; i++) r_buf[i] <= r_buf[i-1];
            // Once five bytes are held, the oldest can no longer be part of the FCS.
            if (w_buf_full) begin
              m_valid <= 1'b1;
              m_data  <= r_buf[4];
            end
          end else begin
            r_state      <= ST_IDLE;
            stat_valid   <= 1'b1;
            stat_crc_err <= ~w_crc_match;
            stat_len_err <= w_len_err;
            stat_phy_err <= r_phy_err;
            if (w_buf_full) begin
              m_valid <= 1'b1;
              m_last  <= 1'b1;
              m_data  <= r_buf[4];
            end
          end
        end
        ST_DROP: begin
          if (!rx_dv) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef ETH_RX_STATS_EN
  logic w_fin;
  logic w_fin_bad;

  assign w_fin     = (r_state == ST_DATA) && !rx_dv;
  assign w_fin_bad = ~w_crc_match | w_len_err | r_phy_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_good <= 32'd0;
      cnt_bad  <= 32'd0;
    end else if (w_fin) begin
      if (w_fin_bad) cnt_bad  <= cnt_bad + 32'd1;
      else           cnt_good <= cnt_good + 32'd1;
    end
  end
`else
  assign cnt_good = 32'd0;
  assign cnt_bad  = 32'd0;
`endif

endmodule

// File: tb/tb_eth_rx_mac.sv
// Scoreboard bench for eth_rx_mac: drivers push expected bytes/status, a negedge monitor
// pops and compares whenever the DUT presents output.
module tb_eth_rx_mac;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_dv;
  logic        rx_er;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        stat_valid;
  logic        stat_crc_err;
  logic        stat_len_err;
  logic        stat_phy_err;
  logic [31:0] cnt_good;
  logic [31:0] cnt_bad;
  logic [1:0]  dbg_state;

  logic [8:0]  exp_q[$];
  logic [2:0]  exp_stat_q[$];
  logic [7:0]  tx_q[$];
  logic [8:0]  mon_e;
  logic [2:0]  mon_s;
  int          errors = 0;
  int          checks = 0;
  int          exp_good = 0;
  int          exp_bad = 0;

  eth_rx_mac #(.PREAMBLE_MIN(7)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_dv        (rx_dv),
    .rx_er        (rx_er),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_last       (m_last),
    .stat_valid   (stat_valid),
    .stat_crc_err (stat_crc_err),
    .stat_len_err (stat_len_err),
    .stat_phy_err (stat_phy_err),
    .cnt_good     (cnt_good),
    .cnt_bad      (cnt_bad),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Bit-serial reference CRC (LSB first, reflected polynomial).
  function automatic logic [31:0] ref_crc(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int b = 0; b < 8; b++) begin
      fb = c[0] ^ d[b];
      c  = c >> 1;
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  // Drivers
  task automatic drive(input logic dv, input logic er, input logic [7:0] d);
    rx_dv = dv; rx_er = er; rx_data = d;
    @(posedge clk); #1;
  endtask

  task automatic build(input int n, input int pat);
    logic [31:0] c;
    logic [7:0]  b;
    tx_q.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      if (i < 6)       b = 8'hFF;
      else if (i < 12) b = 8'((i - 6) * 17);
      else if (i == 12) b = 8'h08;
      else if (i == 13) b = 8'h00;
      else             b = (pat != 0) ? 8'(i * 3 + 1) : 8'h00;
      tx_q.push_back(b);
      c = ref_crc(c, b);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) tx_q.push_back(8'(c >> (8 * i)));
  endtask

  task automatic send(input int pre_n, input int er_idx);
    for (int i = 0; i < pre_n; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < tx_q.size(); i++) drive(1'b1, (i == er_idx), tx_q[i]);
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic expect_frame(input logic crc_e, input logic len_e, input logic phy_e);
    int l;
    l = tx_q.size();
    for (int k = 0; k <= l - 5; k++) exp_q.push_back({(k == l - 5), tx_q[k]});
    exp_stat_q.push_back({crc_e, len_e, phy_e});
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_good = 0;
      exp_bad  = 0;
    end else begin
      if (m_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL data_unexpected: got data=%02h last=%0b, required no output", m_data, m_last);
        end else begin
          mon_e = exp_q.pop_front();
          if ({m_last, m_data} !== mon_e) begin
            errors++;
            $display("FAIL data_byte: got last=%0b data=%02h, required last=%0b data=%02h",
                     m_last, m_data, mon_e[8], mon_e[7:0]);
          end
        end
      end else if (m_last) begin
        checks++; errors++;
        $display("FAIL last_no_valid: got m_last=1 with m_valid=0, required 0");
      end
      if (stat_valid) begin
        checks++;
        if (exp_stat_q.size() == 0) begin
          errors++;
          $display("FAIL stat_unexpected: got crc=%0b len=%0b phy=%0b, required no status",
                   stat_crc_err, stat_len_err, stat_phy_err);
        end else begin
          mon_s = exp_stat_q.pop_front();
          if ({stat_crc_err, stat_len_err, stat_phy_err} !== mon_s) begin
            errors++;
            $display("FAIL stat_flags: got crc/len/phy=%03b, required %03b",
                     {stat_crc_err, stat_len_err, stat_phy_err}, mon_s);
          end
`ifdef ETH_RX_STATS_EN
          if (mon_s == 3'b000) exp_good++;
          else                 exp_bad++;
`endif
          checks++;
          if ({cnt_good, cnt_bad} !== {32'(exp_good), 32'(exp_bad)}) begin
            errors++;
            $display("FAIL counters: got good=%0d bad=%0d, required good=%0d bad=%0d",
                     cnt_good, cnt_bad, exp_good, exp_bad);
          end
        end
      end else if (stat_crc_err | stat_len_err | stat_phy_err) begin
        checks++; errors++;
        $display("FAIL flags_no_valid: got crc/len/phy=%03b without stat_valid, required 000",
                 {stat_crc_err, stat_len_err, stat_phy_err});
      end
    end
  end

  // Stimulus
  initial begin
    rst_n = 1'b0; rx_dv = 1'b0; rx_er = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({m_valid, m_last, m_data, stat_valid, stat_crc_err, stat_len_err, stat_phy_err} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b last=%0b data=%02h stat=%0b flags=%03b, required all 0",
               m_valid, m_last, m_data, stat_valid, {stat_crc_err, stat_len_err, stat_phy_err});
    end
    checks++;
    if ({cnt_good, cnt_bad} !== 64'd0) begin
      errors++;
      $display("FAIL reset_counters: got good=%0d bad=%0d, required 0 0", cnt_good, cnt_bad);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Good minimum frame, all-zero payload
    build(60, 0); expect_frame(1'b0, 1'b0, 1'b0); send(7, -1);
    // Payload byte 20 corrupted after FCS computed
    build(60, 0); tx_q[34] = 8'h01; expect_frame(1'b1, 1'b0, 1'b0); send(7, -1);
    // 63 bytes, correct FCS
    build(59, 1); expect_frame(1'b0, 1'b1, 1'b0); send(7, -1);
    // 64 bytes with a varied payload
    build(60, 1); expect_frame(1'b0, 1'b0, 1'b0); send(7, -1);
    // FCS-only frame: no data bytes, length error
    build(0, 0); expect_frame(1'b0, 1'b1, 1'b0); send(7, -1);
    // Oversize 1519 streams 1515 bytes
    build(1515, 1); expect_frame(1'b0, 1'b1, 1'b0); send(7, -1);
    // Maximum legal 1518
    build(1514, 1); expect_frame(1'b0, 1'b0, 1'b0); send(7, -1);
    // Short preamble: silently dropped
    build(60, 0); send(3, -1);
    // Start byte not a preamble byte: dropped
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 8'hAA);
    drive(1'b0, 1'b0, 8'h00);
    // PHY error mid-payload
    build(100, 1); expect_frame(1'b0, 1'b0, 1'b1); send(7, 30);
    // Eight preamble bytes still accepted
    build(70, 1); expect_frame(1'b0, 1'b0, 1'b0); send(8, -1);

    // Reset pulsed mid-frame while rx_dv stays high
    build(80, 1);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, tx_q[i]);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, tx_q[3]);
    drive(1'b1, 1'b0, tx_q[4]);
    rst_n = 1'b1;
    for (int i = 5; i < 30; i++) drive(1'b1, 1'b0, tx_q[i]);
    @(negedge clk);
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_midframe_state: got state=%0d, required 0 (idle)", dbg_state);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'h00);
    build(64, 1); expect_frame(1'b0, 1'b0, 1'b0); send(7, -1);

    for (int i = 0; i < 50 && (exp_q.size() != 0 || exp_stat_q.size() != 0); i++) @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || exp_stat_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d bytes and %0d status pending, required 0 0",
               exp_q.size(), exp_stat_q.size());
    end
    checks++;
    if ({cnt_good, cnt_bad} !== {32'(exp_good), 32'(exp_bad)}) begin
      errors++;
      $display("FAIL final_counters: got good=%0d bad=%0d, required good=%0d bad=%0d",
               cnt_good, cnt_bad, exp_good, exp_bad);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_rx_mac.md
# eth_rx_mac

Receive-side MAC framer between the PHY byte interface (GMII-style, one byte per `clk`) and the downstream frame buffer. It strips the preamble and SFD, checks FCS with CRC-32, enforces the 64..1518-byte length limits, and removes the 4 FCS bytes. It forwards the frame bytes as a stream with a last marker and a one-cycle status pulse per frame. There is no backpressure: the downstream stage must accept one byte per cycle.

## Interface
- `PREAMBLE_MIN`, default 7: minimum count of 0x55 bytes before the SFD. Legal range 1..7.
- `clk` in 1: single clock, byte rate.
- `rst_n` in 1: reset. Asynchronous assert, active-low.
- `rx_data` in 8: PHY byte.
- `rx_dv` in 1: PHY data valid. Contiguous for the whole frame.
- `rx_er` in 1: PHY error. Sampled only when `rx_dv`=1.
- `m_data` out 8: frame byte, destination address through payload.
- `m_valid` out 1: `m_data` valid this cycle.
- `m_last` out 1: final non-FCS byte. Only asserted with `m_valid`.
- `stat_valid` out 1: one-cycle end-of-frame status pulse.
- `stat_crc_err`, `stat_len_err`, `stat_phy_err` out 1 each: status flags. Valid only with `stat_valid`, 0 otherwise.
- `cnt_good`, `cnt_bad` out 32 each: frame counters. See Configuration.

## Operation
- **States:** IDLE, PREAMBLE, DATA, DROP.
- **Start detection:** a register `dv_q` holds the previous `rx_dv` and resets to 1. A start is `rx_dv`=1 with `dv_q`=0. This prevents locking onto a frame already in progress after reset.
- **IDLE:**
  - On start with byte 0x55: go to PREAMBLE, preamble count = 1.
  - On start with any other byte: go to DROP.
- **PREAMBLE:**
  - Byte 0x55: count +1, saturating at 7.
  - Byte 0xD5 with count ≥ `PREAMBLE_MIN`: go to DATA. CRC register = 32'hFFFFFFFF, length counter = 0.
  - Byte 0xD5 with count < `PREAMBLE_MIN`, or any other byte: go to DROP.
  - `rx_dv`=0: go to IDLE with no status.
- **DATA:**
  - Each byte with `rx_dv`=1: length +1 (11-bit, saturating at 2047). CRC is updated with the reflected, LSB-first step (poly 32'hEDB88320, no per-byte inversion). The byte is pushed into a 5-deep shift buffer.
  - `rx_er`=1 sets a sticky phy-error flag.
  - `rx_dv`=0: finalize and go to IDLE.
- **Finalize (length L = bytes after SFD, including FCS):**
  - `crc_err` = final CRC ≠ 32'hDEBB20E3.
  - `len_err` = L<64 or L>1518.
  - `phy_err` = sticky flag.
- **DROP:** discards bytes until `rx_dv`=0, then goes to IDLE. Produces no output and no status.
- **Oversize frames** are streamed in full. They are flagged with `len_err`, not truncated.
- **Frames with L≤4** emit no data bytes. `stat_valid` still pulses, with `len_err`=1.
- **Reset value:** all outputs and counters are 0.
- **Reset mid-frame:** the state returns to IDLE and the buffer is cleared. No `m_last` or status is produced for the interrupted frame.

## Timing
- **Data latency:** payload byte k, where k = 0 is the first destination byte, is output with `m_valid` in the cycle after the cycle in which byte k+5 is received.
- **End of frame:** the last data byte (k = L−5) is output with `m_last`=1 in the cycle after the first `rx_dv`=0 cycle.
- **Status timing:** `stat_valid` and the error flags are asserted in that same cycle as `m_last`.
- **Back-to-back frames:** a new start is accepted in the cycle immediately after `rx_dv`=0, i.e. a 1-cycle gap is legal. The output of the previous frame must not be corrupted.
- All outputs are registered.

## Configuration
- **`ETH_RX_STATS_EN` defined:**
  - `cnt_good` increments, wrapping, on each `stat_valid` with all three flags 0.
  - `cnt_bad` increments, wrapping, on each `stat_valid` with any flag set.
  - DROP events are not counted.
- **`ETH_RX_STATS_EN` undefined:** `cnt_good` and `cnt_bad` are tied to 0 and no counter flops are inferred.

## Structure
- The shared rx/tx package holds:
  - `PREAMBLE_BYTE` (0x55), `SFD_BYTE` (0xD5), `MIN_FRAME_SIZE` (64), `MAX_FRAME_SIZE` (1518).
  - `CRC32_POLY_REFLECTED` and the residue constant 32'hDEBB20E3.
  - The per-byte CRC step function.
  - A `typedef enum` for the state.
- One sub-module, `eth_rx_crc_chk`, holds the CRC register: init, update-enable, byte in, match out.

## Test plan
- **Good minimum frame:** 7×0x55, 0xD5, then dst FF×6, src 00 11 22 33 44 55, type 08 00, 46×0x00, then the model FCS → 60 bytes out, `m_last` on the 60th, `stat_valid` with all flags 0, `cnt_good`=1 (with the macro).
- **CRC error:** same frame with payload byte 20 set to 0x01 → 60 bytes out, `stat_crc_err`=1, `stat_len_err`=0.
- **Length limits:**
  - 63-byte frame with a correct FCS → `stat_len_err`=1.
  - 1519-byte frame → `stat_len_err`=1, 1515 bytes out.
- **Short preamble:** 3×0x55 then 0xD5, with `PREAMBLE_MIN`=7 → no `m_valid`, no `stat_valid`.
- **PHY error:** `rx_er`=1 for one cycle mid-payload → `stat_phy_err`=1.
- **Reset mid-frame:** `rst_n` pulsed low mid-frame while `rx_dv` stays high → nothing is output until `rx_dv` falls. The next good frame after a 1-cycle gap is received intact.
